// File: rtl/renderer_pkg.sv
// Renderer screen/sheet constants and FSM state encoding.
package renderer_pkg;

  localparam int DEF_SCREEN_W = 1200;
  localparam int DEF_SCREEN_H = 300;
  localparam int DEF_SHEET_W  = 2448;
  localparam int ROM_AW       = 21;
  localparam int FB_AW        = 19;
  localparam int PIX_W        = 2;

  typedef enum logic [2:0] {
    IDLE,
    SLOT,
    FETCH,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/runner_pkg.sv
// Sprite slot types shared with the game-runner side.
package runner_pkg;

  localparam int RENDER_SLOTS = 32;

  typedef struct packed {
    logic [11:0] x;
    logic [9:0]  y;
    logic [7:0]  w;
    logic [7:0]  h;
  } sprite_t;

  typedef struct packed {
    logic signed [10:0] x;
    logic [9:0]         y;
  } pos_t;

endpackage

// File: rtl/sprite_addr_gen.sv
// Clip test plus sheet and framebuffer addresses for one sprite pixel.
module sprite_addr_gen
  import renderer_pkg::*;
  import runner_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int SHEET_W  = DEF_SHEET_W
) (
  input  sprite_t           spr_i,
  input  pos_t              pos_i,
  input  logic [7:0]        row_i,
  input  logic [7:0]        col_i,
  output logic              clip_o,
  output logic [ROM_AW-1:0] rom_addr_o,
  output logic [FB_AW-1:0]  fb_addr_o
);

  localparam logic [31:0] SCR_W = 32'(SCREEN_W);
  localparam logic [31:0] SHT_W = 32'(SHEET_W);
  localparam logic [11:0] LIM_X = 12'(SCREEN_W);
  localparam logic [11:0] LIM_Y = 12'(SCREEN_H);

  logic [11:0] scr_x;
  logic [11:0] scr_y;

  // Bit 11 of scr_x is the sign of the 12-bit screen X.
  assign scr_x = {pos_i.x[10], pos_i.x} + {4'b0, col_i};
  assign scr_y = {2'b0, pos_i.y} + {4'b0, row_i};

  assign clip_o = scr_x[11]
                | (scr_x >= LIM_X)
                | (scr_y >= LIM_Y);

  assign rom_addr_o = ROM_AW'(
    (32'(spr_i.y) + 32'(row_i)) * SHT_W
    + 32'(spr_i.x) + 32'(col_i));

  assign fb_addr_o = FB_AW'(
    32'(scr_y) * SCR_W + 32'(scr_x));

endmodule

// File: rtl/sprite_renderer.sv
// Walks snapshot sprite slots and blits opaque pixels into the framebuffer.
module sprite_renderer
  import renderer_pkg::*;
  import runner_pkg::sprite_t;
  import runner_pkg::pos_t;
#(
  parameter int RENDER_SLOTS = runner_pkg::RENDER_SLOTS,
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int SCREEN_H     = DEF_SCREEN_H,
  parameter int SHEET_W      = DEF_SHEET_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  sprite_t           sprite [RENDER_SLOTS],
  input  pos_t              pos [RENDER_SLOTS],
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  output logic              fb_we,
  output logic [FB_AW-1:0]  fb_addr,
  output logic [PIX_W-1:0]  fb_data,
  input  logic              fb_ready
);

  localparam int SW = (RENDER_SLOTS > 1) ? $clog2(RENDER_SLOTS) : 1;
  localparam logic [SW-1:0] LAST = SW'(RENDER_SLOTS - 1);

  state_e           state_q, state_d;
  logic [SW-1:0]    slot_q, slot_d;
  logic [7:0]       row_q, row_d;
  logic [7:0]       col_q, col_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             first_q, first_d;

  sprite_t sprite_q [RENDER_SLOTS];
  pos_t    pos_q [RENDER_SLOTS];

  sprite_t           cur_spr;
  pos_t              cur_pos;
  logic              clip;
  logic [ROM_AW-1:0] ag_rom;
  logic [FB_AW-1:0]  ag_fb;
  logic [PIX_W-1:0]  pix;
  logic              adv;

  assign cur_spr = sprite_q[slot_q];
  assign cur_pos = pos_q[slot_q];

  sprite_addr_gen #(
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H),
    .SHEET_W (SHEET_W)
  ) u_ag (
    .spr_i     (cur_spr),
    .pos_i     (cur_pos),
    .row_i     (row_q),
    .col_i     (col_q),
    .clip_o    (clip),
    .rom_addr_o(ag_rom),
    .fb_addr_o (ag_fb)
  );

  always_ff @(posedge clk) begin
    if (!rst && state_q == IDLE && start) begin
      sprite_q <= sprite;
      pos_q    <= pos;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      pix_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      row_q   <= row_d;
      col_q   <= col_d;
      pix_q   <= pix_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    row_d    = row_q;
    col_d    = col_q;
    pix_d    = pix_q;
    first_d  = 1'b0;
    adv      = 1'b0;
    busy     = (state_q != IDLE);
    done     = 1'b0;
    rom_en   = 1'b0;
    rom_addr = '0;
    fb_we    = 1'b0;
    fb_addr  = '0;
    fb_data  = '0;
    // ROM data is only valid one cycle; later stall cycles replay pix_q.
    pix      = first_q ? rom_data : pix_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SLOT;
          slot_d  = '0;
        end
      end
      SLOT: begin
        if (cur_spr.w == 8'd0 || cur_spr.h == 8'd0) begin
          if (slot_q == LAST) state_d = DONE;
          else slot_d = slot_q + 1'b1;
        end else begin
          row_d   = '0;
          col_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (clip) begin
          adv = 1'b1;
        end else begin
          rom_en   = 1'b1;
          rom_addr = ag_rom;
          first_d  = 1'b1;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        pix_d = pix;
        if (pix == '0) begin
          adv = 1'b1;
        end else begin
          fb_we   = 1'b1;
          fb_addr = ag_fb;
          fb_data = pix;
          adv     = fb_ready;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (adv) begin
      state_d = FETCH;
      if (col_q == cur_spr.w - 8'd1) begin
        col_d = '0;
        if (row_q == cur_spr.h - 8'd1) begin
          row_d = '0;
          if (slot_q == LAST) begin
            state_d = DONE;
          end else begin
            slot_d  = slot_q + 1'b1;
            state_d = SLOT;
          end
        end else begin
          row_d = row_q + 8'd1;
        end
      end else begin
        col_d = col_q + 8'd1;
      end
    end

    // Abort takes effect in the reset cycle itself.
    if (rst) begin
      busy     = 1'b0;
      done     = 1'b0;
      rom_en   = 1'b0;
      rom_addr = '0;
      fb_we    = 1'b0;
      fb_addr  = '0;
      fb_data  = '0;
    end
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer with ROM model and write monitor.
module tb_sprite_renderer;
  import runner_pkg::*;

  localparam int NS    = 32;
  localparam int LIMIT = 40000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  sprite_t     spr_in [NS];
  pos_t        pos_in [NS];
  logic        busy, done, rom_en, fb_we;
  logic [20:0] rom_addr;
  logic [1:0]  rom_data = 2'd0;
  logic [18:0] fb_addr;
  logic [1:0]  fb_data;
  logic        fb_ready = 1'b1;

  always #5 clk = ~clk;

  sprite_renderer #(
    .RENDER_SLOTS(NS),
    .SCREEN_W(1200),
    .SCREEN_H(300),
    .SHEET_W(2448)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .sprite(spr_in), .pos(pos_in),
    .busy(busy), .done(done),
    .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data),
    .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_data(fb_data), .fb_ready(fb_ready)
  );

  int total = 0;
  int passed = 0;

  int wr_cnt, rom_cnt, done_cnt, stall_err;
  int first_fb, last_fb, first_rom, last_rom, last_dat;
  int rom_mode = 0;
  bit stall_en = 1'b0;
  int stall_left = 0;
  bit prev_stall = 1'b0;
  logic [18:0] prev_addr;
  logic [1:0]  prev_data;
  logic [1:0]  fbmem [int];

  function automatic logic [1:0] rom_fn(input logic [20:0] a);
    return (rom_mode == 0) ? 2'd2 : a[1:0];
  endfunction

  always @(posedge clk)
    rom_data <= rom_en ? rom_fn(rom_addr) : 2'd0;

  always @(negedge clk) begin
    if (stall_en && fb_we && stall_left > 0) begin
      fb_ready = 1'b0;
      stall_left--;
    end else begin
      fb_ready = 1'b1;
    end
    if (prev_stall)
      if (!(fb_we && fb_addr == prev_addr && fb_data == prev_data))
        stall_err++;
    prev_stall = fb_we && !fb_ready;
    prev_addr  = fb_addr;
    prev_data  = fb_data;
    if (fb_we && fb_ready) begin
      wr_cnt++;
      if (first_fb < 0) first_fb = int'(fb_addr);
      last_fb  = int'(fb_addr);
      last_dat = int'(fb_data);
      fbmem[int'(fb_addr)] = fb_data;
    end
    if (rom_en) begin
      rom_cnt++;
      if (first_rom < 0) first_rom = int'(rom_addr);
      last_rom = int'(rom_addr);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string nm, input longint act,
                     input longint req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, req);
  endtask

  task automatic clear_mon();
    wr_cnt = 0; rom_cnt = 0; done_cnt = 0; stall_err = 0;
    first_fb = -1; last_fb = -1; last_dat = -1;
    first_rom = -1; last_rom = -1;
    prev_stall = 1'b0;
  endtask

  task automatic clear_in();
    for (int i = 0; i < NS; i++) begin
      spr_in[i] = '0;
      pos_in[i] = '0;
    end
  endtask

  task automatic set_one(input int s, input sprite_t sp, input pos_t p);
    clear_in();
    spr_in[s] = sp;
    pos_in[s] = p;
  endtask

  task automatic run_frame(output int cyc);
    clear_mon();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    clear_in();
    chk("busy_after_start", longint'(busy), 1);
    cyc = 1;
    while (!done && cyc < LIMIT) begin
      start = (cyc == 5);
      @(posedge clk); #1 cyc++;
    end
    start = 1'b0;
    chk("done_within_limit", longint'(cyc < LIMIT), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_back_idle", longint'(busy), 0);
  endtask

  typedef struct {
    int      slot;
    sprite_t spr;
    pos_t    p;
    int      mode;
    int      wr, rom, ffb, lfb, from, lrom, ldat;
  } vec_t;

  vec_t tab [7];

  initial begin
    int cyc;
    tab[0] = '{29, '{12'd1678, 10'd2, 8'd88, 8'd94},
               '{11'sd100, 10'd200}, 0,
               8272, 8272, 240100, 351787, 6574, 234325, 2};
    tab[1] = '{0, '{12'd0, 10'd0, 8'd20, 8'd1},
               '{-11'sd10, 10'd0}, 0,
               10, 10, 0, 9, 10, 19, 2};
    tab[2] = '{5, '{12'd10, 10'd10, 8'd200, 8'd2},
               '{11'sd1020, 10'd0}, 0,
               360, 360, 1020, 2399, 24490, 27117, 2};
    tab[3] = '{31, '{12'd0, 10'd0, 8'd3, 8'd5},
               '{11'sd0, 10'd297}, 0,
               9, 9, 356400, 358802, 0, 4898, 2};
    tab[4] = '{2, '{12'd0, 10'd0, 8'd8, 8'd1},
               '{11'sd0, 10'd0}, 1,
               6, 8, 1, 7, 0, 7, 3};
    tab[5] = '{10, '{12'd0, 10'd0, 8'd50, 8'd2},
               '{-11'sd100, 10'd0}, 0,
               0, 0, -1, -1, -1, -1, -1};
    tab[6] = '{7, '{12'd2000, 10'd800, 8'd4, 8'd3},
               '{11'sd50, 10'd60}, 0,
               12, 12, 72050, 74453, 1960400, 1965299, 2};

    clear_in();
    clear_mon();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_rom_en", longint'(rom_en), 0);
    chk("rst_fb_we", longint'(fb_we), 0);
    chk("rst_rom_addr", longint'(rom_addr), 0);
    chk("rst_fb_addr", longint'(fb_addr), 0);
    chk("rst_fb_data", longint'(fb_data), 0);

    clear_in();
    run_frame(cyc);
    chk("empty_cycles", cyc, 33);
    chk("empty_rom_en", rom_cnt, 0);
    chk("empty_writes", wr_cnt, 0);
    chk("empty_done", done_cnt, 1);

    for (int k = 0; k < 7; k++) begin
      set_one(tab[k].slot, tab[k].spr, tab[k].p);
      rom_mode = tab[k].mode;
      run_frame(cyc);
      chk($sformatf("v%0d_writes", k), wr_cnt, tab[k].wr);
      chk($sformatf("v%0d_rom_en", k), rom_cnt, tab[k].rom);
      chk($sformatf("v%0d_first_fb", k), first_fb, tab[k].ffb);
      chk($sformatf("v%0d_last_fb", k), last_fb, tab[k].lfb);
      chk($sformatf("v%0d_first_rom", k), first_rom, tab[k].from);
      chk($sformatf("v%0d_last_rom", k), last_rom, tab[k].lrom);
      chk($sformatf("v%0d_last_data", k), last_dat, tab[k].ldat);
      chk($sformatf("v%0d_done", k), done_cnt, 1);
    end

    set_one(3, '{12'd0, 10'd0, 8'd4, 8'd1}, '{11'sd7, 10'd7});
    rom_mode = 0;
    stall_en = 1'b1;
    stall_left = 5;
    run_frame(cyc);
    stall_en = 1'b0;
    chk("stall_writes", wr_cnt, 4);
    chk("stall_first_fb", first_fb, 8407);
    chk("stall_last_fb", last_fb, 8410);
    chk("stall_stable", stall_err, 0);
    chk("stall_cycles", cyc, 46);
    chk("stall_done", done_cnt, 1);

    set_one(0, '{12'd1, 10'd0, 8'd1, 8'd1}, '{11'sd5, 10'd5});
    spr_in[30] = '{12'd3, 10'd0, 8'd1, 8'd1};
    pos_in[30] = '{11'sd5, 10'd5};
    rom_mode = 1;
    run_frame(cyc);
    chk("overlap_writes", wr_cnt, 2);
    chk("overlap_final", longint'(fbmem[6005]), 3);

    set_one(29, tab[0].spr, tab[0].p);
    rom_mode = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    clear_mon();
    @(posedge clk); #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_writes", wr_cnt, 0);
    chk("abort_rom_en", rom_cnt, 0);
    chk("abort_done", done_cnt, 0);
    chk("abort_busy", longint'(busy), 0);

    set_one(tab[6].slot, tab[6].spr, tab[6].p);
    run_frame(cyc);
    chk("after_abort_writes", wr_cnt, 12);
    chk("after_abort_first", first_fb, 72050);
    chk("after_abort_done", done_cnt, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sprite_renderer.md
SPRITE_RENDERER -- requirements
Module: sprite_renderer

Interface
REQ-001 SHALL have parameter RENDER_SLOTS, default 32, number of render slots walked per frame.
REQ-002 SHALL have parameter SCREEN_W, default 1200, framebuffer width in pixels.
REQ-003 SHALL have parameter SCREEN_H, default 300, framebuffer height in pixels.
REQ-004 SHALL have parameter SHEET_W, default 2448, sprite-sheet row pitch in pixels.
REQ-005 Ports; one clock, reset synchronous active-high:
  clk  in  1  system clock
  rst  in  1  synchronous active-high reset
  start  in  1  pulse: render one frame from current slot inputs
  sprite  in  sprite_t[RENDER_SLOTS]  sheet x, y, w, h per slot
  pos  in  pos_t[RENDER_SLOTS]  screen x (signed 11b), y per slot
  busy  out  1  high from accepted start until done
  done  out  1  one-cycle pulse when the frame is finished
  rom_en  out  1  sprite ROM read strobe
  rom_addr  out  21  sprite ROM pixel address
  rom_data  in  2  pixel, valid cycle after rom_en; 0 = transparent
  fb_we  out  1  framebuffer write request
  fb_addr  out  19  framebuffer pixel address
  fb_data  out  2  pixel value
  fb_ready  in  1  framebuffer accepts write this cycle

Function
REQ-006 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-007 SHALL snapshot all sprite and pos entries in the start-accept cycle; input changes afterwards SHALL NOT affect the frame.
REQ-008 SHALL use FSM states IDLE, SLOT, FETCH, WRITE, DONE.
REQ-009 IDLE->SLOT on start; busy asserts the following cycle.
REQ-010 SLOT: slot with w==0 or h==0 SHALL be skipped in one cycle; else row=col=0, go FETCH.
REQ-011 Slots SHALL be processed in ascending index; later slots overwrite earlier ones (painter's order).
REQ-012 Per pixel: screen X = signed pos.x + col, Y = pos.y + row, both computed 12-bit signed.
REQ-013 Pixel with X<0, X>=SCREEN_W or Y>=SCREEN_H SHALL be clipped: no rom_en, no fb_we, advance next cycle.
REQ-014 FETCH, unclipped: rom_en=1, rom_addr=(sprite.y+row)*SHEET_W+sprite.x+col; go WRITE.
REQ-015 WRITE: rom_data==0 SHALL advance without writing; else hold fb_we=1, fb_addr=Y*SCREEN_W+X, fb_data=rom_data stable until fb_ready=1.
REQ-016 Write completes in the cycle fb_we&&fb_ready; minimum 2 cycles per opaque pixel.
REQ-017 Advance: col++ until col==w-1, then col=0,row++; after row==h-1 go SLOT with next index.
REQ-018 After slot RENDER_SLOTS-1: DONE for one cycle, done=1, then IDLE with busy=0.
REQ-019 fb_we SHALL never be asserted outside WRITE; rom_en never outside FETCH.
REQ-020 Address arithmetic SHALL be unsigned, wide enough to avoid overflow before truncation to port widths.

Reset
REQ-021 rst SHALL force IDLE, busy=0, done=0, rom_en=0, fb_we=0, addresses/data=0, slot/row/col counters=0.
REQ-022 rst mid-frame SHALL abort immediately; no further writes, no done pulse.

Structure
REQ-023 Screen/sheet constants and FSM state enum SHALL live in a shared package renderer_pkg; sprite_t, pos_t, RENDER_SLOTS SHALL be taken from runner_pkg.
REQ-024 A single sub-module sprite_addr_gen SHALL compute clip flags and both addresses from snapshot slot, row, col.

Verification
REQ-025 Slot 29 = {x=1678,y=2,w=88,h=94}, pos {100,200}, all-opaque ROM, fb_ready=1 -> 8272 writes, first fb_addr=240100, done once.
REQ-026 All slots w=0, start -> done exactly 33 cycles after start-accept, zero rom_en/fb_we.
REQ-027 Slot 0 pos.x=-10 (11'h7F6), w=20,h=1 -> only cols 10..19 written, fb_addr 0..9.
REQ-028 fb_ready held low 5 cycles on first write -> fb_addr/fb_data stable, no pixel lost or duplicated.
REQ-029 Slots 0 and 30 overlap same pixel, values 1 then 3 -> last write to that address is 3.
REQ-030 rst asserted mid-frame, then start -> no writes after rst, new frame completes with one done.
